// File: rtl/div37by19_pkg.sv
// rtl/div37by19_pkg.sv - shared widths, limits and FSM states for the 37/19 signed divider
package div37by19_pkg;
   localparam int DW   = 36;
   localparam int QW   = 19;
   localparam int MAGW = 18;

   localparam logic [MAGW-1:0] QMAX = 18'h3FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;
endpackage

// File: rtl/div37by19.sv
// rtl/div37by19.sv - signed 37-bit (product format) by 19-bit restoring divider
// with quotient saturation, divide-by-zero flag and registered results.
module div37by19
   import div37by19_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW:0]   a,
   input  logic [QW-1:0] b,
   output logic [QW-1:0] q,
   output logic [QW-1:0] r,
   output logic          busy,
   output logic          done,
   output logic          dz,
   output logic          ovf
);
   state_t          r_state;
   logic [DW-1:0]   r_dvd;
   logic [MAGW-1:0] r_rem;
   logic [MAGW-1:0] r_div;
   logic [5:0]      r_cnt;
   logic            r_sign_q;
   logic            r_sign_r;
   logic            r_dz;

   logic [DW-1:0]   w_amag;
   logic [MAGW-1:0] w_bneg;
   logic [MAGW-1:0] w_bmag;
   logic [MAGW:0]   w_trial;
   logic            w_ge;
   logic [MAGW-1:0] w_sub;
   logic            w_ovf;
   logic [MAGW-1:0] w_qmag;
   logic [QW-1:0]   w_qpos;
   logic [QW-1:0]   w_rpos;
   logic [QW-1:0]   w_qsgn;
   logic [QW-1:0]   w_rsgn;

   assign w_amag = a[DW] ? (~a[DW-1:0] + 36'd1) : a[DW-1:0];
   assign w_bneg = ~b[MAGW-1:0] + 18'd1;
   // The most negative divisor has no 18-bit magnitude, so it is folded to -(2^18-1).
   assign w_bmag = (b == 19'h40000) ? QMAX : (b[QW-1] ? w_bneg : b[MAGW-1:0]);

   assign w_trial = {r_rem, r_dvd[DW-1]};
   assign w_ge    = (w_trial >= {1'b0, r_div});
   assign w_sub   = w_trial[MAGW-1:0] - r_div;

   assign w_ovf  = |r_dvd[DW-1:MAGW];
   assign w_qmag = w_ovf ? QMAX : r_dvd[MAGW-1:0];
   assign w_qpos = {1'b0, w_qmag};
   assign w_rpos = {1'b0, r_rem};
   assign w_qsgn = r_sign_q ? (~w_qpos + 19'd1) : w_qpos;
   assign w_rsgn = r_sign_r ? (~w_rpos + 19'd1) : w_rpos;

   assign busy = (r_state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_dvd    <= '0;
         r_rem    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_dz     <= 1'b0;
         q        <= '0;
         r        <= '0;
         done     <= 1'b0;
         dz       <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_dvd    <= w_amag;
                  r_rem    <= '0;
                  r_div    <= w_bmag;
                  r_cnt    <= 6'd35;
                  r_sign_q <= a[DW] ^ b[QW-1];
                  r_sign_r <= a[DW];
                  r_dz     <= (b == '0);
                  r_state  <= (b == '0) ? FIX : CALC;
               end
            end
            CALC: begin
               // Quotient bits shift into r_dvd as the dividend bits shift out.
               r_rem <= w_ge ? w_sub : w_trial[MAGW-1:0];
               r_dvd <= {r_dvd[DW-2:0], w_ge};
               r_cnt <= r_cnt - 6'd1;
               if (r_cnt == 6'd0) r_state <= FIX;
            end
            FIX: begin
               if (r_dz) begin
                  q   <= '0;
                  r   <= '0;
                  dz  <= 1'b1;
                  ovf <= 1'b0;
               end else begin
                  q   <= w_qsgn;
                  r   <= w_rsgn;
                  dz  <= 1'b0;
                  ovf <= w_ovf;
               end
               done    <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div37by19.sv
// tb/tb_div37by19.sv - self-checking bench for div37by19: directed table,
// random vectors against an arithmetic model, reset and busy-start sequences.
module tb_div37by19;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic [36:0] a;
   logic [18:0] b;
   logic [18:0] q;
   logic [18:0] r;
   logic        busy;
   logic        done;
   logic        dz;
   logic        ovf;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [36:0] a;
      logic [18:0] b;
      logic [18:0] q;
      logic [18:0] r;
      logic        dz;
      logic        ovf;
      int          lat;
   } vec_t;

   div37by19 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .q     (q),
      .r     (r),
      .busy  (busy),
      .done  (done),
      .dz    (dz),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t model(input logic [36:0] ia, input logic [18:0] ib);
      vec_t   v;
      longint ma, mb, sb, qm, rm;
      v.a = ia;
      v.b = ib;
      if (ib == 19'd0) begin
         v.q = '0; v.r = '0; v.dz = 1'b1; v.ovf = 1'b0; v.lat = 1;
         return v;
      end
      ma = ia[36] ? (((longint'(1) << 36) - longint'(ia[35:0])) % (longint'(1) << 36))
                  : longint'(ia[35:0]);
      sb = longint'($signed(ib));
      mb = (sb == -262144) ? 262143 : ((sb < 0) ? -sb : sb);
      qm = ma / mb;
      rm = ma % mb;
      v.ovf = (qm > 262143);
      if (v.ovf) qm = 262143;
      v.q   = 19'((ia[36] ^ ib[18]) ? -qm : qm);
      v.r   = 19'(ia[36] ? -rm : rm);
      v.dz  = 1'b0;
      v.lat = 37;
      return v;
   endfunction

   // Caller is #1 past a rising edge with the DUT idle; returns #1 past the done edge.
   task automatic run(input logic [36:0] ia, input logic [18:0] ib,
                      output logic [18:0] oq, output logic [18:0] orr,
                      output logic odz, output logic oovf, output int lat);
      a = ia;
      b = ib;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = 37'({$urandom, $urandom});
      b = 19'($urandom);
      lat = -1;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      oq = q; orr = r; odz = dz; oovf = ovf;
   endtask

   task automatic check_vec(input string nm, input vec_t v);
      logic [18:0] gq, gr;
      logic        gdz, govf;
      int          glat;
      run(v.a, v.b, gq, gr, gdz, govf, glat);
      chk({nm, ".q"},   64'(gq),   64'(v.q));
      chk({nm, ".r"},   64'(gr),   64'(v.r));
      chk({nm, ".dz"},  64'(gdz),  64'(v.dz));
      chk({nm, ".ovf"}, 64'(govf), 64'(v.ovf));
      chk({nm, ".lat"}, 64'(glat), 64'(v.lat));
   endtask

   vec_t tbl[10];

   initial begin
      logic [18:0] gq, gr;
      logic        gdz, govf;
      int          glat, ndone;
      logic [18:0] sq, sr;
      logic signed [18:0] x, y;
      logic signed [37:0] p;
      logic [36:0] ra;
      logic [18:0] rb;

      tbl[0] = '{{1'b1, 36'hF_FFFB_6C20}, 19'h7FED4, 19'h003E8, 19'h00000, 1'b0, 1'b0, 37};
      tbl[1] = '{37'd100,                 19'd7,     19'h0000E, 19'h00002, 1'b0, 1'b0, 37};
      tbl[2] = '{{1'b1, 36'hF_FFFF_FF9C}, 19'd7,     19'h7FFF2, 19'h7FFFE, 1'b0, 1'b0, 37};
      tbl[3] = '{37'd100,                 19'd0,     19'h00000, 19'h00000, 1'b1, 1'b0, 1};
      tbl[4] = '{37'h0_0010_0000,         19'd1,     19'h3FFFF, 19'h00000, 1'b0, 1'b1, 37};
      tbl[5] = '{37'd100,                 19'h40000, 19'h00000, 19'd100,   1'b0, 1'b0, 37};
      tbl[6] = '{{1'b1, 36'h0},           19'd5,     19'h00000, 19'h00000, 1'b0, 1'b0, 37};
      tbl[7] = '{{1'b1, 36'hF_FFFF_FFFF}, 19'd7,     19'h00000, 19'h7FFFF, 1'b0, 1'b0, 37};
      tbl[8] = '{37'd786431,              19'd3,     19'h3FFFF, 19'h00002, 1'b0, 1'b0, 37};
      tbl[9] = '{37'd786432,              19'h7FFFD, 19'h40001, 19'h00000, 1'b0, 1'b1, 37};

      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      #1;
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.done", 64'(done), 64'd0);
      chk("rst.q",    64'(q),    64'd0);
      chk("rst.r",    64'(r),    64'd0);
      chk("rst.flags", 64'({dz, ovf}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) check_vec($sformatf("tbl%0d", i), tbl[i]);

      // Results hold and done drops after the pulse.
      @(posedge clk);
      #1;
      chk("hold.done", 64'(done), 64'd0);
      chk("hold.q",    64'(q),    64'(tbl[9].q));
      chk("hold.ovf",  64'(ovf),  64'd1);

      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) begin
            ra = 37'({$urandom, $urandom});
         end else begin
            x  = 19'($urandom);
            y  = 19'($urandom);
            p  = 38'(x) * 38'(y);
            ra = {p[37], p[35:0]};
         end
         case (i % 8)
            0:       rb = 19'd0;
            1:       rb = 19'h40000;
            2:       rb = 19'($urandom_range(1, 15));
            default: rb = 19'($urandom);
         endcase
         check_vec($sformatf("rnd%0d", i), model(ra, rb));
      end

      // Reset mid-CALC: outputs clear immediately, the division is abandoned.
      a = 37'd100; b = 19'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("mid.busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst.busy", 64'(busy), 64'd0);
      chk("arst.outs", 64'({q, r, dz, ovf, done}), 64'd0);
      ndone = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      chk("arst.nodone", 64'(ndone), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // A start pulsed while busy must be ignored.
      a = 37'd100; b = 19'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      a = 37'd5; b = 19'd1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      ndone = 0;
      sq = '1; sr = '1;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (done) begin
            if (ndone == 0) begin sq = q; sr = r; end
            ndone++;
         end
      end
      chk("busy_start.ndone", 64'(ndone), 64'd1);
      chk("busy_start.q",     64'(sq),    64'd14);
      chk("busy_start.r",     64'(sr),    64'd2);

      run(37'd100, 19'd0, gq, gr, gdz, govf, glat);
      chk("post.dz", 64'(gdz), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
